// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  regfile_pkg : shared types and defaults for the multi-port register file
//  Revision    : 1.0
// ============================================================================
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int DEPTH_DEF = 32;

   typedef enum logic {RF_READY, RF_CLEAR} rf_state_t;

   function automatic int rf_aw(input int depth);
      return $clog2(depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  regfile_mp_if : read/write/debug bus of the multi-port register file
//  Revision      : 1.0
// ============================================================================
interface regfile_mp_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5,
   parameter int NRD  = 2
);
   logic [NRD*AW-1:0]   ra;
   logic [NRD*XLEN-1:0] rd;
   logic                we;
   logic [AW-1:0]       wa;
   logic [XLEN-1:0]     wd;
   logic [AW-1:0]       dbg_a;
   logic [XLEN-1:0]     dbg_d;
   logic                busy;

   modport master (output ra, we, wa, wd, dbg_a, input rd, dbg_d, busy);
   modport slave  (input ra, we, wa, wd, dbg_a, output rd, dbg_d, busy);
endinterface
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// ============================================================================
//  regfile_clear_fsm : post-reset sequencer that walks entries 1..DEPTH-1 to 0
//  Revision          : 1.0
// ============================================================================
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  wire logic          clk,
   input  wire logic          rst,
   output logic               busy,
   output logic               clr_we,
   output logic [AW-1:0]      clr_addr
);

   rf_state_t     r_state;
   logic [AW-1:0] r_cnt;
   logic          r_busy;

   // Reset only arms the sequence; the walk itself runs once rst drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RF_CLEAR;
         r_cnt   <= AW'(1);
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            RF_CLEAR: begin
               if (r_cnt == AW'(DEPTH - 1)) begin
                  r_state <= RF_READY;
                  r_busy  <= 1'b0;
                  r_cnt   <= AW'(1);
               end else begin
                  r_cnt   <= r_cnt + AW'(1);
               end
            end
            RF_READY: begin
               r_busy <= 1'b0;
            end
            default: begin
               r_state <= RF_CLEAR;
               r_cnt   <= AW'(1);
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign clr_we   = r_busy;
   assign clr_addr = r_cnt;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  regfile_mp : NRD-read / 1-write register file, x0 hardwired, debug tap
//  Revision   : 1.0
// ============================================================================
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  wire logic   clk,
   input  wire logic   rst,
   regfile_mp_if.slave bus
);

   localparam int AW = rf_aw(DEPTH);

   logic [XLEN-1:0] r_mem [1:DEPTH-1];
   logic            w_busy;
   logic            w_clr_we;
   logic [AW-1:0]   w_clr_addr;

   regfile_clear_fsm #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear (
      .clk      (clk),
      .rst      (rst),
      .busy     (w_busy),
      .clr_we   (w_clr_we),
      .clr_addr (w_clr_addr)
   );

   // Clear owns the port while busy, so functional writes never collide with it.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[w_clr_addr] <= '0;
      end else if (bus.we && (bus.wa != '0) && !rst) begin
         r_mem[bus.wa] <= bus.wd;
      end
   end

   generate
      for (genvar i = 0; i < NRD; i++) begin : g_rd
         logic [AW-1:0]   w_ra;
         logic [XLEN-1:0] w_rd;

         assign w_ra = bus.ra[i*AW +: AW];

         always_comb begin
            w_rd = '0;
            if (!w_busy) begin
               if ((BYPASS != 0) && bus.we && (bus.wa == w_ra) && (bus.wa != '0)) begin
                  w_rd = bus.wd;
               end else if (w_ra != '0) begin
                  w_rd = r_mem[w_ra];
               end
            end
         end

         assign bus.rd[i*XLEN +: XLEN] = w_rd;
      end
   endgenerate

   always_comb begin
      bus.dbg_d = '0;
      if (!w_busy && (bus.dbg_a != '0)) begin
         bus.dbg_d = r_mem[bus.dbg_a];
      end
   end

   assign bus.busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  tb_regfile_mp : directed bench, one BYPASS=1/NRD=4 and one BYPASS=0/NRD=2 DUT
//  Revision      : 1.0
// ============================================================================
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(4)) ifa ();
   regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(2)) ifb ();

   regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(4), .BYPASS(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(2), .BYPASS(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wr(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
      ifa.we = we;  ifa.wa = wa;  ifa.wd = wd;
      ifb.we = we;  ifb.wa = wa;  ifb.wd = wd;
   endtask

   task automatic drive_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] a3);
      ifa.ra = {a3, a2, a1, a0};
      ifb.ra = {a1, a0};
   endtask

   task automatic drive_dbg(input logic [AW-1:0] a);
      ifa.dbg_a = a;
      ifb.dbg_a = a;
   endtask

   // Counts busy cycles of each DUT, checking outputs are masked while busy.
   task automatic count_busy(output int na, output int nb);
      na = 0;
      nb = 0;
      for (int i = 0; i < 40; i++) begin
         if (ifa.busy !== 1'b1 && ifb.busy !== 1'b1) break;
         if (ifa.busy === 1'b1) begin
            na++;
            check_eq("clr_rd0_a", ifa.rd[31:0], 32'h0);
            check_eq("clr_dbg_a", ifa.dbg_d, 32'h0);
         end
         if (ifb.busy === 1'b1) begin
            nb++;
            check_eq("clr_rd0_b", ifb.rd[31:0], 32'h0);
         end
         step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int na;
      int nb;

      // T1: reset and initial clear
      rst = 1'b1;
      drive_wr(1'b0, '0, '0);
      drive_ra(5'd5, 5'd5, 5'd5, 5'd5);
      drive_dbg(5'd5);
      step();
      rst = 1'b0;
      #1;
      check_eq("rst_busy_a", {31'b0, ifa.busy}, 32'd1);
      check_eq("rst_busy_b", {31'b0, ifb.busy}, 32'd1);
      count_busy(na, nb);
      check_eq("busy_cycles_a", na, 32'd31);
      check_eq("busy_cycles_b", nb, 32'd31);
      check_eq("busy_low_a", {31'b0, ifa.busy}, 32'd0);
      check_eq("cleared_rd5_a", ifa.rd[31:0], 32'h0);

      // T2: bypass vs. no bypass in the write cycle
      drive_wr(1'b1, 5'd5, 32'hDEADBEEF);
      drive_ra(5'd5, 5'd5, 5'd5, 5'd5);
      #1;
      check_eq("byp_same_a", ifa.rd[31:0], 32'hDEADBEEF);
      check_eq("nobyp_same_b", ifb.rd[31:0], 32'h0);
      step();
      drive_wr(1'b0, '0, '0);
      #1;
      check_eq("byp_next_a", ifa.rd[31:0], 32'hDEADBEEF);
      check_eq("nobyp_next_b", ifb.rd[31:0], 32'hDEADBEEF);

      // T3: x0 write dropped, reads zero
      drive_wr(1'b1, 5'd0, 32'hFFFFFFFF);
      drive_ra(5'd0, 5'd0, 5'd0, 5'd0);
      #1;
      check_eq("x0_same_rd0_a", ifa.rd[31:0], 32'h0);
      check_eq("x0_same_rd1_a", ifa.rd[63:32], 32'h0);
      check_eq("x0_same_rd0_b", ifb.rd[31:0], 32'h0);
      check_eq("x0_same_rd1_b", ifb.rd[63:32], 32'h0);
      step();
      drive_wr(1'b0, '0, '0);
      #1;
      check_eq("x0_next_rd0_a", ifa.rd[31:0], 32'h0);
      check_eq("x0_next_rd1_b", ifb.rd[63:32], 32'h0);

      // T4: fill 1..31 with i*3, all ports on one address, debug tap
      for (int i = 1; i < DEPTH; i++) begin
         drive_wr(1'b1, AW'(i), 32'(i * 3));
         step();
      end
      drive_wr(1'b0, '0, '0);
      drive_ra(5'd10, 5'd10, 5'd10, 5'd10);
      drive_dbg(5'd10);
      #1;
      check_eq("fill_rd0_a", ifa.rd[31:0], 32'd30);
      check_eq("fill_rd1_a", ifa.rd[63:32], 32'd30);
      check_eq("fill_rd2_a", ifa.rd[95:64], 32'd30);
      check_eq("fill_rd3_a", ifa.rd[127:96], 32'd30);
      check_eq("fill_dbg_a", ifa.dbg_d, 32'd30);
      check_eq("fill_rd0_b", ifb.rd[31:0], 32'd30);
      drive_ra(5'd31, 5'd1, 5'd2, 5'd5);
      drive_dbg(5'd0);
      #1;
      check_eq("mix_rd0_a", ifa.rd[31:0], 32'd93);
      check_eq("mix_rd1_a", ifa.rd[63:32], 32'd3);
      check_eq("mix_rd2_a", ifa.rd[95:64], 32'd6);
      check_eq("mix_rd3_a", ifa.rd[127:96], 32'd15);
      check_eq("dbg_x0_b", ifb.dbg_d, 32'h0);

      // T5/T6: reg7=0x55, re-reset mid-clear at cnt=12, writes during busy dropped
      drive_wr(1'b1, 5'd7, 32'h55);
      step();
      drive_wr(1'b0, '0, '0);
      drive_ra(5'd7, 5'd7, 5'd7, 5'd7);
      drive_dbg(5'd7);
      #1;
      check_eq("r7_rd0_a", ifa.rd[31:0], 32'h55);
      check_eq("r7_rd0_b", ifb.rd[31:0], 32'h55);
      check_eq("r7_dbg_b", ifb.dbg_d, 32'h55);

      drive_ra(5'd3, 5'd7, 5'd3, 5'd7);
      drive_wr(1'b1, 5'd3, 32'h1234);
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (11) step();
      check_eq("mid_busy_a", {31'b0, ifa.busy}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      count_busy(na, nb);
      check_eq("rerst_cycles_a", na, 32'd31);
      check_eq("rerst_cycles_b", nb, 32'd31);
      drive_wr(1'b0, '0, '0);
      #1;
      check_eq("drop_rd0_a", ifa.rd[31:0], 32'h0);
      check_eq("clr7_rd1_a", ifa.rd[63:32], 32'h0);
      check_eq("drop_rd0_b", ifb.rd[31:0], 32'h0);
      check_eq("clr7_rd1_b", ifb.rd[63:32], 32'h0);
      check_eq("clr7_dbg_a", ifa.dbg_d, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
